// File: rtl/l2_line_update_pkg.sv
// Shared L2 / Spandex types and constants for the line-update slice.
//
// Provides the default L2 geometry (ways, sets, words per line, tag width),
// the Spandex per-word state encoding (SPX_I must stay 0: an all-zero line
// is an invalid line), the sized scalar types used on the update and RAM
// buses, and the update FSM state type.
package l2_line_update_pkg;

    localparam int L2_WAYS        = 8;
    localparam int L2_SETS        = 256;
    localparam int WORDS_PER_LINE = 4;
    localparam int L2_TAG_BITS    = 20;
    localparam int SPX_STATE_BITS = 3;

    localparam int L2_WAY_W  = $clog2(L2_WAYS);
    localparam int L2_SET_W  = $clog2(L2_SETS);
    localparam int L2_LINE_W = WORDS_PER_LINE * SPX_STATE_BITS;

    typedef enum logic [SPX_STATE_BITS-1:0] {
        SPX_I = 3'd0,
        SPX_V = 3'd1,
        SPX_S = 3'd2,
        SPX_R = 3'd3
    } state_t;

    typedef logic [L2_WAY_W-1:0]       l2_way_t;
    typedef logic [L2_SET_W-1:0]       l2_set_t;
    typedef logic [L2_TAG_BITS-1:0]    l2_tag_t;
    typedef logic [WORDS_PER_LINE-1:0] word_mask_t;
    typedef logic [L2_LINE_W-1:0]      line_states_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WRITE   = 2'd3
    } upd_fsm_t;

endpackage

// File: rtl/l2_line_update_if.sv
// Bus interfaces for l2_line_update.
//
// l2_upd_if : request side, driven by the L2 controller FSM (master) and
//             consumed by l2_line_update (slave).
//   upd_valid/upd_ready handshake, upd_set/way/tag/write_tag/word_mask/
//   state/advance_evict request fields, upd_done and line_empty completion
//   pulses back to the controller.
// l2_ram_if : tag/state RAM port, driven by l2_line_update (master) and
//             served by the RAM (slave).
//   rd_en/rd_set read request, rd_tag/rd_states read data one cycle after
//   rd_en, wr_en/wr_set/wr_way/wr_tag/wr_states write request.
interface l2_upd_if
    import l2_line_update_pkg::*;
#(
    parameter int WAYS       = L2_WAYS,
    parameter int WORDS      = WORDS_PER_LINE,
    parameter int SETS       = L2_SETS,
    parameter int TAG_BITS   = L2_TAG_BITS,
    parameter int STATE_BITS = SPX_STATE_BITS
) ();

    logic                       upd_valid;
    logic                       upd_ready;
    logic [$clog2(SETS)-1:0]    upd_set;
    logic [$clog2(WAYS)-1:0]    upd_way;
    logic [TAG_BITS-1:0]        upd_tag;
    logic                       upd_write_tag;
    logic [WORDS-1:0]           upd_word_mask;
    logic [STATE_BITS-1:0]      upd_state;
    logic                       upd_advance_evict;
    logic                       upd_done;
    logic                       line_empty;

    modport master (
        output upd_valid, upd_set, upd_way, upd_tag, upd_write_tag,
               upd_word_mask, upd_state, upd_advance_evict,
        input  upd_ready, upd_done, line_empty
    );

    modport slave (
        input  upd_valid, upd_set, upd_way, upd_tag, upd_write_tag,
               upd_word_mask, upd_state, upd_advance_evict,
        output upd_ready, upd_done, line_empty
    );

endinterface

interface l2_ram_if
    import l2_line_update_pkg::*;
#(
    parameter int WAYS       = L2_WAYS,
    parameter int WORDS      = WORDS_PER_LINE,
    parameter int SETS       = L2_SETS,
    parameter int TAG_BITS   = L2_TAG_BITS,
    parameter int STATE_BITS = SPX_STATE_BITS
) ();

    logic                          rd_en;
    logic [$clog2(SETS)-1:0]       rd_set;
    logic [TAG_BITS-1:0]           rd_tag;
    logic [WORDS*STATE_BITS-1:0]   rd_states;
    logic                          wr_en;
    logic [$clog2(SETS)-1:0]       wr_set;
    logic [$clog2(WAYS)-1:0]       wr_way;
    logic [TAG_BITS-1:0]           wr_tag;
    logic [WORDS*STATE_BITS-1:0]   wr_states;

    modport master (
        output rd_en, rd_set, wr_en, wr_set, wr_way, wr_tag, wr_states,
        input  rd_tag, rd_states
    );

    modport slave (
        input  rd_en, rd_set, wr_en, wr_set, wr_way, wr_tag, wr_states,
        output rd_tag, rd_states
    );

endinterface

// File: rtl/l2_line_update_evict_ptr.sv
// l2_evict_ptr: per-set round-robin eviction pointer array.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset (clears every pointer)
//   upd_en      write ptr[upd_set] <= upd_ptr this cycle
//   upd_set     set whose pointer is written
//   upd_ptr     new pointer value
//   lookup_set  set queried by the lookup stage
//   evict_way   registered ptr[lookup_set], valid one cycle after lookup_set
//
// A write to the queried set is forwarded so evict_way never shows the stale
// pointer for the cycle after the write.
module l2_evict_ptr
    import l2_line_update_pkg::*;
#(
    parameter int SETS = L2_SETS,
    parameter int WAYS = L2_WAYS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd_en,
    input  logic [$clog2(SETS)-1:0] upd_set,
    input  logic [$clog2(WAYS)-1:0] upd_ptr,
    input  logic [$clog2(SETS)-1:0] lookup_set,
    output logic [$clog2(WAYS)-1:0] evict_way
);

    localparam int WAY_W = $clog2(WAYS);

    logic [WAY_W-1:0] ptr [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SETS; i++) begin
                ptr[i] <= '0;
            end
            evict_way <= '0;
        end else begin
            if (upd_en) begin
                ptr[upd_set] <= upd_ptr;
            end
            // Same-edge forwarding of a write to the queried set.
            if (upd_en && (upd_set == lookup_set)) begin
                evict_way <= upd_ptr;
            end else begin
                evict_way <= ptr[lookup_set];
            end
        end
    end

endmodule

// File: rtl/l2_line_update.sv
// l2_line_update: read-modify-write of one L2 way's tag and per-word Spandex
// states, plus the per-set round-robin eviction pointers.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   upd         l2_upd_if.slave  - request handshake, fields, done/empty pulses
//   ram         l2_ram_if.master - tag/state RAM read and write port
//   lookup_set  set queried for its eviction pointer
//   evict_way   registered eviction way for lookup_set
//
// One update every four cycles: accept (IDLE), read strobe (READ), capture
// of RAM data (CAPTURE), merged write (WRITE). All RAM-side and completion
// outputs are zero outside the state that drives them.
module l2_line_update
    import l2_line_update_pkg::*;
#(
    parameter int WAYS       = L2_WAYS,
    parameter int WORDS      = WORDS_PER_LINE,
    parameter int SETS       = L2_SETS,
    parameter int TAG_BITS   = L2_TAG_BITS,
    parameter int STATE_BITS = SPX_STATE_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    l2_upd_if.slave                 upd,
    l2_ram_if.master                ram,
    input  logic [$clog2(SETS)-1:0] lookup_set,
    output logic [$clog2(WAYS)-1:0] evict_way
);

    localparam int SET_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int LINE_W = WORDS * STATE_BITS;

    // Replace the state of every masked word; unmasked words keep the stored state.
    function automatic logic [LINE_W-1:0] merge_states(
        input logic [LINE_W-1:0]     stored,
        input logic [WORDS-1:0]      mask,
        input logic [STATE_BITS-1:0] new_state
    );
        logic [LINE_W-1:0] merged;
        merged = stored;
        for (int j = 0; j < WORDS; j++) begin
            if (mask[j]) begin
                merged[j*STATE_BITS +: STATE_BITS] = new_state;
            end
        end
        return merged;
    endfunction

    function automatic logic line_all_invalid(input logic [LINE_W-1:0] states);
        logic empty;
        empty = 1'b1;
        for (int j = 0; j < WORDS; j++) begin
            if (states[j*STATE_BITS +: STATE_BITS] != STATE_BITS'(SPX_I)) begin
                empty = 1'b0;
            end
        end
        return empty;
    endfunction

    upd_fsm_t state, state_nxt;

    logic [SET_W-1:0]      req_set_p0;
    logic [WAY_W-1:0]      req_way_p0;
    logic [TAG_BITS-1:0]   req_tag_p0;
    logic                  req_write_tag_p0;
    logic [WORDS-1:0]      req_mask_p0;
    logic [STATE_BITS-1:0] req_state_p0;
    logic                  req_advance_p0;

    logic [TAG_BITS-1:0]   rd_tag_p1;
    logic [LINE_W-1:0]     rd_states_p1;

    logic [LINE_W-1:0]     merged_states;
    logic [TAG_BITS-1:0]   merged_tag;
    logic                  merged_empty;

    logic                  ptr_upd_en;
    logic [WAY_W-1:0]      ptr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage p0: request fields latched on acceptance.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && upd.upd_valid) begin
            req_set_p0       <= upd.upd_set;
            req_way_p0       <= upd.upd_way;
            req_tag_p0       <= upd.upd_tag;
            req_write_tag_p0 <= upd.upd_write_tag;
            req_mask_p0      <= upd.upd_word_mask;
            req_state_p0     <= upd.upd_state;
            req_advance_p0   <= upd.upd_advance_evict;
        end
    end

    // Stage p1: RAM read data, valid the cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (state == ST_CAPTURE) begin
            rd_tag_p1    <= ram.rd_tag;
            rd_states_p1 <= ram.rd_states;
        end
    end

    // Stage p2: merge feeding the write port.
    always_comb begin
        merged_states = merge_states(rd_states_p1, req_mask_p0, req_state_p0);
        merged_tag    = req_write_tag_p0 ? req_tag_p0 : rd_tag_p1;
        merged_empty  = line_all_invalid(merged_states);
    end

    always_comb begin
        state_nxt      = state;
        upd.upd_ready  = 1'b0;
        upd.upd_done   = 1'b0;
        upd.line_empty = 1'b0;
        ram.rd_en      = 1'b0;
        ram.rd_set     = '0;
        ram.wr_en      = 1'b0;
        ram.wr_set     = '0;
        ram.wr_way     = '0;
        ram.wr_tag     = '0;
        ram.wr_states  = '0;
        ptr_upd_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                upd.upd_ready = 1'b1;
                if (upd.upd_valid) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                ram.rd_en  = 1'b1;
                ram.rd_set = req_set_p0;
                state_nxt  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                ram.wr_en      = 1'b1;
                ram.wr_set     = req_set_p0;
                ram.wr_way     = req_way_p0;
                ram.wr_tag     = merged_tag;
                ram.wr_states  = merged_states;
                upd.upd_done   = 1'b1;
                upd.line_empty = merged_empty;
                ptr_upd_en     = req_advance_p0;
                state_nxt      = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Round-robin: the way just filled becomes most recent, so point past it
    // (natural wrap of the WAY_W-bit sum takes WAYS-1 back to 0).
    assign ptr_next = req_way_p0 + WAY_W'(1);

    l2_evict_ptr #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_evict_ptr (
        .clk        (clk),
        .rst        (rst),
        .upd_en     (ptr_upd_en),
        .upd_set    (req_set_p0),
        .upd_ptr    (ptr_next),
        .lookup_set (lookup_set),
        .evict_way  (evict_way)
    );

endmodule

// File: tb/tb_l2_line_update.sv
// Directed bench for l2_line_update: expected RAM writes are queued when a
// request is driven and compared when wr_en is seen; cycle-level handshake,
// read strobe and eviction-pointer behaviour is checked inline.
module tb_l2_line_update;
    import l2_line_update_pkg::*;

    typedef struct {
        l2_set_t      set;
        l2_way_t      way;
        l2_tag_t      tag;
        line_states_t states;
        logic         empty;
    } exp_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    l2_set_t lookup_set = '0;
    l2_way_t evict_way;

    l2_tag_t      stored_tag    = '0;
    line_states_t stored_states = '0;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    l2_upd_if u_if ();
    l2_ram_if r_if ();

    l2_line_update dut (
        .clk        (clk),
        .rst        (rst),
        .upd        (u_if.slave),
        .ram        (r_if.master),
        .lookup_set (lookup_set),
        .evict_way  (evict_way)
    );

    always #5 clk = ~clk;

    // RAM model: read data is only meaningful in the cycle after rd_en.
    always @(posedge clk) begin
        if (r_if.rd_en) begin
            r_if.rd_tag    <= stored_tag;
            r_if.rd_states <= stored_states;
        end else begin
            r_if.rd_tag    <= l2_tag_t'($urandom());
            r_if.rd_states <= '1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic line_states_t pack4(state_t w0, state_t w1, state_t w2, state_t w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample at #1, and retire any RAM write against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (r_if.wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 64'(r_if.wr_en), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_set",     64'(r_if.wr_set),    64'(e.set));
                chk("wr_way",     64'(r_if.wr_way),    64'(e.way));
                chk("wr_tag",     64'(r_if.wr_tag),    64'(e.tag));
                chk("wr_states",  64'(r_if.wr_states), 64'(e.states));
                chk("upd_done",   64'(u_if.upd_done),  64'd1);
                chk("line_empty", 64'(u_if.line_empty), 64'(e.empty));
            end
        end else begin
            chk("idle_done",  64'(u_if.upd_done),   64'd0);
            chk("idle_empty", 64'(u_if.line_empty), 64'd0);
        end
    endtask

    task automatic drive(input l2_set_t s, input l2_way_t w, input l2_tag_t t, input logic wt,
                         input word_mask_t m, input state_t st, input logic adv);
        u_if.upd_set           = s;
        u_if.upd_way           = w;
        u_if.upd_tag           = t;
        u_if.upd_write_tag     = wt;
        u_if.upd_word_mask     = m;
        u_if.upd_state         = st;
        u_if.upd_advance_evict = adv;
        u_if.upd_valid         = 1'b1;
    endtask

    task automatic push(input l2_set_t s, input l2_way_t w, input l2_tag_t t,
                        input line_states_t st, input logic empty);
        exp_t e;
        e.set = s; e.way = w; e.tag = t; e.states = st; e.empty = empty;
        sb.push_back(e);
    endtask

    // Single update, checked cycle by cycle from accept (cycle 0) to cycle 4.
    task automatic issue(input l2_set_t s, input l2_way_t w, input l2_tag_t t, input logic wt,
                         input word_mask_t m, input state_t st, input logic adv,
                         input l2_tag_t exp_tag, input line_states_t exp_states,
                         input logic exp_empty, input l2_way_t exp_evict);
        drive(s, w, t, wt, m, st, adv);
        chk("c0_ready", 64'(u_if.upd_ready), 64'd1);
        push(s, w, exp_tag, exp_states, exp_empty);
        tick();
        u_if.upd_valid = 1'b0;
        chk("c1_rd_en",  64'(r_if.rd_en),     64'd1);
        chk("c1_rd_set", 64'(r_if.rd_set),    64'(s));
        chk("c1_ready",  64'(u_if.upd_ready), 64'd0);
        chk("c1_wr_en",  64'(r_if.wr_en),     64'd0);
        tick();
        chk("c2_rd_en",  64'(r_if.rd_en),     64'd0);
        chk("c2_ready",  64'(u_if.upd_ready), 64'd0);
        chk("c2_wr_en",  64'(r_if.wr_en),     64'd0);
        tick();
        chk("c3_wr_en",  64'(r_if.wr_en),     64'd1);
        chk("c3_ready",  64'(u_if.upd_ready), 64'd0);
        tick();
        chk("c4_ready",  64'(u_if.upd_ready), 64'd1);
        chk("c4_wr_en",  64'(r_if.wr_en),     64'd0);
        chk("c4_evict",  64'(evict_way),      64'(exp_evict));
    endtask

    initial begin
        u_if.upd_valid         = 1'b0;
        u_if.upd_set           = '0;
        u_if.upd_way           = '0;
        u_if.upd_tag           = '0;
        u_if.upd_write_tag     = 1'b0;
        u_if.upd_word_mask     = '0;
        u_if.upd_state         = '0;
        u_if.upd_advance_evict = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 64'(u_if.upd_ready),  64'd1);
        chk("rst_rd_en", 64'(r_if.rd_en),      64'd0);
        chk("rst_wr_en", 64'(r_if.wr_en),      64'd0);
        chk("rst_done",  64'(u_if.upd_done),   64'd0);
        chk("rst_empty", 64'(u_if.line_empty), 64'd0);
        chk("rst_evict", 64'(evict_way),       64'd0);

        // Partial state update with tag write
        stored_tag    = 20'h11111;
        stored_states = pack4(SPX_S, SPX_S, SPX_I, SPX_I);
        issue(8'd5, 3'd2, 20'hABCDE, 1'b1, 4'b0101, SPX_R, 1'b0,
              20'hABCDE, pack4(SPX_R, SPX_S, SPX_R, SPX_I), 1'b0, 3'd0);

        // Invalidate whole line, keep stored tag
        stored_tag    = 20'h12345;
        stored_states = pack4(SPX_S, SPX_R, SPX_V, SPX_S);
        issue(8'd6, 3'd4, 20'hFFFFF, 1'b0, 4'b1111, SPX_I, 1'b0,
              20'h12345, pack4(SPX_I, SPX_I, SPX_I, SPX_I), 1'b1, 3'd0);

        // Evict pointer advance with forwarding, then wrap from way 7
        lookup_set    = 8'd9;
        stored_tag    = 20'h13579;
        stored_states = pack4(SPX_V, SPX_V, SPX_V, SPX_V);
        issue(8'd9, 3'd3, 20'h99999, 1'b0, 4'b0010, SPX_S, 1'b1,
              20'h13579, pack4(SPX_V, SPX_S, SPX_V, SPX_V), 1'b0, 3'd4);
        stored_tag    = 20'h00000;
        issue(8'd9, 3'd7, 20'h24680, 1'b1, 4'b0000, SPX_R, 1'b1,
              20'h24680, pack4(SPX_V, SPX_V, SPX_V, SPX_V), 1'b0, 3'd0);
        lookup_set = 8'd10;
        tick();
        chk("evict_set10", 64'(evict_way), 64'd0);
        lookup_set = 8'd9;
        tick();
        chk("evict_set9_wrapped", 64'(evict_way), 64'd0);

        // Back-to-back with upd_valid held
        stored_tag    = 20'h00001;
        stored_states = pack4(SPX_I, SPX_I, SPX_I, SPX_I);
        lookup_set    = 8'd21;
        drive(8'd20, 3'd1, 20'h2A2A2, 1'b1, 4'b1000, SPX_V, 1'b0);
        chk("b2b_c0_ready", 64'(u_if.upd_ready), 64'd1);
        push(8'd20, 3'd1, 20'h2A2A2, pack4(SPX_I, SPX_I, SPX_I, SPX_V), 1'b0);
        tick();
        chk("b2b_c1_rd_en",  64'(r_if.rd_en),     64'd1);
        chk("b2b_c1_rd_set", 64'(r_if.rd_set),    64'd20);
        chk("b2b_c1_ready",  64'(u_if.upd_ready), 64'd0);
        drive(8'd21, 3'd6, 20'h77777, 1'b0, 4'b0011, SPX_I, 1'b1);
        push(8'd21, 3'd6, 20'h0BEEF, pack4(SPX_I, SPX_I, SPX_I, SPX_I), 1'b1);
        tick();
        chk("b2b_c2_ready", 64'(u_if.upd_ready), 64'd0);
        tick();
        chk("b2b_c3_ready", 64'(u_if.upd_ready), 64'd0);
        chk("b2b_c3_wr_en", 64'(r_if.wr_en),     64'd1);
        tick();
        chk("b2b_c4_ready", 64'(u_if.upd_ready), 64'd1);
        chk("b2b_c4_rd_en", 64'(r_if.rd_en),     64'd0);
        stored_tag    = 20'h0BEEF;
        stored_states = pack4(SPX_R, SPX_S, SPX_I, SPX_I);
        tick();
        u_if.upd_valid = 1'b0;
        chk("b2b_c5_rd_en",  64'(r_if.rd_en),  64'd1);
        chk("b2b_c5_rd_set", 64'(r_if.rd_set), 64'd21);
        tick();
        tick();
        chk("b2b_c7_wr_en", 64'(r_if.wr_en), 64'd1);
        tick();
        chk("b2b_c8_ready", 64'(u_if.upd_ready), 64'd1);
        chk("b2b_c8_evict", 64'(evict_way),      64'd7);

        // Reset during CAPTURE aborts the update
        stored_tag    = 20'h55555;
        stored_states = pack4(SPX_V, SPX_V, SPX_V, SPX_V);
        drive(8'd30, 3'd2, 20'h66666, 1'b1, 4'b1111, SPX_I, 1'b1);
        tick();
        u_if.upd_valid = 1'b0;
        chk("abort_c1_rd_en", 64'(r_if.rd_en), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", 64'(u_if.upd_ready), 64'd1);
        chk("abort_wr_en", 64'(r_if.wr_en),     64'd0);
        chk("abort_done",  64'(u_if.upd_done),  64'd0);
        chk("abort_evict", 64'(evict_way),      64'd0);
        lookup_set = 8'd21;
        tick();
        chk("abort_evict21", 64'(evict_way), 64'd0);
        lookup_set = 8'd30;
        tick();
        chk("abort_evict30", 64'(evict_way), 64'd0);
        chk("abort_wr_en2",  64'(r_if.wr_en), 64'd0);
        lookup_set = 8'd0;
        tick();
        chk("abort_evict0", 64'(evict_way), 64'd0);

        // Empty mask: states unchanged, tag still written
        stored_tag    = 20'h0AAAA;
        stored_states = pack4(SPX_S, SPX_I, SPX_R, SPX_I);
        issue(8'd40, 3'd5, 20'h55555, 1'b1, 4'b0000, SPX_V, 1'b0,
              20'h55555, pack4(SPX_S, SPX_I, SPX_R, SPX_I), 1'b0, 3'd0);
        stored_states = pack4(SPX_I, SPX_I, SPX_I, SPX_I);
        issue(8'd41, 3'd0, 20'hC0FFE, 1'b1, 4'b0000, SPX_R, 1'b0,
              20'hC0FFE, pack4(SPX_I, SPX_I, SPX_I, SPX_I), 1'b1, 3'd0);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
